// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select-mux scan sequencer assembling one parallel frame per scan
// Frames leave over a valid/ready handshake; a lost frame sets the sticky overrun flag.
module mux_scan_ctrl #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_in,
  output logic [NUM_CH-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [3:0]        dwell_q, dwell_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic [SEL_W-1:0]  low_idx;
  logic [SEL_W-1:0]  nxt_idx;
  logic              nxt_found;
  logic [NUM_CH-1:0] merged;
  logic              publish;
  logic [NUM_CH-1:0] pub_data;
  logic              clr_ovr;
  logic              consume;

  // Channel search: lowest enabled in the live mask, next enabled above sel in the latched mask.
  always_comb begin
    low_idx   = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_idx = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        nxt_idx   = SEL_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    merged         = shadow_q;
    merged[sel_q]  = mux_in;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    publish  = 1'b0;
    pub_data = '0;
    clr_ovr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            mask_d  = ch_mask;
            clr_ovr = 1'b1;
            sel_d   = low_idx;
            dwell_d = '0;
            state_d = SCAN;
          end else begin
            publish  = 1'b1;
            pub_data = '0;
          end
        end
      end
      SCAN: begin
        if (dwell_q == 4'(SETTLE)) begin
          shadow_d = merged;
          dwell_d  = '0;
          if (nxt_found) begin
            sel_d = nxt_idx;
          end else begin
            publish  = 1'b1;
            pub_data = merged & mask_q;
            // Continuous mode picks up the live mask only at the frame boundary.
            if (continuous) begin
              mask_d = ch_mask;
              if (|ch_mask) begin
                sel_d = low_idx;
              end else begin
                sel_d   = '0;
                state_d = IDLE;
              end
            end else begin
              sel_d   = '0;
              state_d = IDLE;
            end
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A publish on the consuming edge replaces the frame without counting as an overrun.
  always_comb begin
    consume   = valid_q & data_ready;
    data_d    = publish ? pub_data : data_q;
    valid_d   = publish | (valid_q & ~consume);
    overrun_d = clr_ovr ? 1'b0 : (overrun_q | (publish & valid_q & ~data_ready));
    busy_d    = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      dwell_q   <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dwell_q   <= dwell_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign sel        = sel_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl
// Two instances: SETTLE=0 for most scenarios, SETTLE=2 for dwell timing.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [3:0] ch_mask;
  logic       data_ready;

  logic [1:0] sel0, sel2;
  logic [3:0] data0, data2;
  logic       dv0, dv2, busy0, busy2, ovr0, ovr2;
  logic       mux0, mux2;
  logic [3:0] x0, x2;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  int checks;
  int failures;

  assign mux0 = x0[sel0];
  assign mux2 = x2[sel2];

  mux_scan_ctrl #(.NUM_CH(4), .SEL_W(2), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .sel(sel0), .mux_in(mux0), .data(data0),
    .data_valid(dv0), .data_ready(data_ready), .busy(busy0), .overrun(ovr0)
  );

  mux_scan_ctrl #(.NUM_CH(4), .SEL_W(2), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .sel(sel2), .mux_in(mux2), .data(data2),
    .data_valid(dv2), .data_ready(data_ready), .busy(busy2), .overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = 4'b0;
    data_ready = 1'b0; x0 = 4'b0; x2 = 4'b0;
    #3;
    checks++;
    if ({sel0, data0, dv0, busy0, ovr0} !== 9'b0) begin
      failures++;
      $display("FAIL reset_dut0 got=%b want=0", {sel0, data0, dv0, busy0, ovr0});
    end
    checks++;
    if ({sel2, data2, dv2, busy2, ovr2} !== 9'b0) begin
      failures++;
      $display("FAIL reset_dut2 got=%b want=0", {sel2, data2, dv2, busy2, ovr2});
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_settle;
    logic [1:0] seq [6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
    ch_mask = 4'b0101; x2 = 4'b1111; start = 1'b1;
    exp_q.push_back(4'b0101);
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (sel2 !== seq[k] || dv2 !== 1'b0) begin
        failures++;
        $display("FAIL settle_sel k=%0d got sel=%0d valid=%b want sel=%0d valid=0", k, sel2, dv2, seq[k]);
      end
      step();
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (dv2 !== 1'b1 || data2 !== exp_v || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL settle_frame got valid=%b data=%b busy=%b want valid=1 data=%b busy=0", dv2, data2, busy2, exp_v);
    end
  endtask

  task automatic test_basic;
    drain();
    ch_mask = 4'b1111; x0 = 4'b1010; start = 1'b1;
    exp_q.push_back(4'b1010);
    step();
    start = 1'b0;
    ch_mask = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sel0 !== 2'(k) || busy0 !== 1'b1 || dv0 !== 1'b0) begin
        failures++;
        $display("FAIL basic_sel k=%0d got sel=%0d busy=%b valid=%b want sel=%0d busy=1 valid=0", k, sel0, busy0, dv0, k);
      end
      step();
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (dv0 !== 1'b1 || data0 !== exp_v || busy0 !== 1'b0 || sel0 !== 2'd0) begin
      failures++;
      $display("FAIL basic_frame got valid=%b data=%b busy=%b sel=%0d want valid=1 data=%b busy=0 sel=0", dv0, data0, busy0, sel0, exp_v);
    end
    ch_mask = 4'b1111;
  endtask

  task automatic test_continuous_overrun;
    drain();
    continuous = 1'b1; data_ready = 1'b0; ch_mask = 4'b1111; x0 = 4'b0011;
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1100);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c < 12) begin
        checks++;
        if (busy0 !== 1'b1) begin
          failures++;
          $display("FAIL cont_busy c=%0d got=%b want=1", c, busy0);
        end
      end
      if (c == 4 || c == 8 || c == 12) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (dv0 !== 1'b1 || data0 !== exp_v || ovr0 !== (c != 4)) begin
          failures++;
          $display("FAIL cont_frame c=%0d got valid=%b data=%b ovr=%b want valid=1 data=%b ovr=%b", c, dv0, data0, ovr0, exp_v, (c != 4));
        end
      end
      if (c == 4) x0 = 4'b1100;
      if (c == 8) continuous = 1'b0;
    end
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL cont_idle got busy=%b want=0", busy0);
    end
  endtask

  task automatic test_back_to_back;
    drain();
    continuous = 1'b1; data_ready = 1'b0; ch_mask = 4'b1111; x0 = 4'b0110;
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b1001);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 4) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (dv0 !== 1'b1 || data0 !== exp_v || sel0 !== 2'd0 || busy0 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_first got valid=%b data=%b sel=%0d busy=%b want valid=1 data=%b sel=0 busy=1", dv0, data0, sel0, busy0, exp_v);
        end
        x0 = 4'b1001;
      end
      if (c == 7) data_ready = 1'b1;
      if (c == 8) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (dv0 !== 1'b1 || data0 !== exp_v || ovr0 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_same_edge got valid=%b data=%b ovr=%b want valid=1 data=%b ovr=0", dv0, data0, ovr0, exp_v);
        end
        continuous = 1'b0;
      end
      if (c == 9) begin
        checks++;
        if (dv0 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_consume got valid=%b want=0", dv0);
        end
      end
      if (c == 12) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (dv0 !== 1'b1 || data0 !== exp_v || busy0 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_last got valid=%b data=%b busy=%b want valid=1 data=%b busy=0", dv0, data0, busy0, exp_v);
        end
        data_ready = 1'b0;
      end
    end
  endtask

  task automatic test_mask_zero_and_start_ignored;
    drain();
    continuous = 1'b0; ch_mask = 4'b0000; start = 1'b1;
    exp_q.push_back(4'b0000);
    step();
    start = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (dv0 !== 1'b1 || data0 !== exp_v || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL mask0_frame got valid=%b data=%b busy=%b want valid=1 data=%b busy=0", dv0, data0, busy0, exp_v);
    end
    step();
    checks++;
    if (busy0 !== 1'b0 || dv0 !== 1'b1) begin
      failures++;
      $display("FAIL mask0_idle got busy=%b valid=%b want busy=0 valid=1", busy0, dv0);
    end
    drain();
    ch_mask = 4'b1111; x0 = 4'b1010; start = 1'b1;
    exp_q.push_back(4'b1010);
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sel0 !== 2'(k)) begin
        failures++;
        $display("FAIL midstart_sel k=%0d got=%0d want=%0d", k, sel0, k);
      end
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      step();
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (dv0 !== 1'b1 || data0 !== exp_v || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL midstart_frame got valid=%b data=%b busy=%b want valid=1 data=%b busy=0", dv0, data0, busy0, exp_v);
    end
  endtask

  task automatic test_reset_midscan;
    drain();
    ch_mask = 4'b1111; x0 = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel0, data0, dv0, busy0, ovr0} !== 9'b0) begin
      failures++;
      $display("FAIL midscan_reset got=%b want=0", {sel0, data0, dv0, busy0, ovr0});
    end
    step();
    rst_n = 1'b1;
    step();
    x0 = 4'b0101; start = 1'b1;
    exp_q.push_back(4'b0101);
    step();
    start = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || sel0 !== 2'd0) begin
      failures++;
      $display("FAIL fresh_start got busy=%b sel=%0d want busy=1 sel=0", busy0, sel0);
    end
    for (int k = 0; k < 4; k++) step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dv0 !== 1'b1 || data0 !== exp_v) begin
      failures++;
      $display("FAIL fresh_frame got valid=%b data=%b want valid=1 data=%b", dv0, data0, exp_v);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_settle();
    test_basic();
    test_continuous_overrun();
    test_back_to_back();
    test_mask_zero_and_start_ignored();
    test_reset_midscan();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
